// File: rtl/instruction_decode_queue.sv
// RV32 fetch-to-decode buffer: DEPTH-entry FIFO feeding a registered decode stage.
// Optional macro ILLEGAL_DETECT_EN enables the registered illegal-instruction flag.
module instruction_decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [31:0]                   in_instr,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [6:0]                    opcode,
    output logic [4:0]                    rd,
    output logic [2:0]                    func3,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [6:0]                    func7,
    output logic [XLEN-1:0]               imm,
    output logic [2:0]                    fmt,
    output logic                          illegal,
    output logic [$clog2(DEPTH+2)-1:0]    count
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int CWO = $clog2(DEPTH+2);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd6;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;

    logic        xfer, ld, fifo_empty, pop, bypass, push;
    logic [31:0] src;
    logic [2:0]  dec_fmt;
    logic [31:0] imm32;
    logic [XLEN-1:0] dec_imm;

    assign in_ready   = fifo_cnt < CW'(DEPTH);
    assign xfer       = in_valid && in_ready;
    assign ld         = !out_valid || out_ready;
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = ld && !fifo_empty;
    // An empty FIFO lets the incoming word go straight into the output register.
    assign bypass     = ld && fifo_empty && xfer;
    assign push       = xfer && !bypass;
    assign src        = fifo_empty ? in_instr : mem[rd_ptr];
    assign count      = CWO'(fifo_cnt) + CWO'(out_valid);

    always_comb begin
        dec_fmt = FMT_NONE;
        case (src[6:0])
            7'b0110011:                                     dec_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
            7'b0100011:                                     dec_fmt = FMT_S;
            7'b1100011:                                     dec_fmt = FMT_B;
            7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
            7'b1101111:                                     dec_fmt = FMT_J;
            default:                                        dec_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        case (dec_fmt)
            FMT_I:   imm32 = {{20{src[31]}}, src[31:20]};
            FMT_S:   imm32 = {{20{src[31]}}, src[31:25], src[11:7]};
            FMT_B:   imm32 = {{19{src[31]}}, src[31], src[7], src[30:25], src[11:8], 1'b0};
            FMT_U:   imm32 = {src[31:12], 12'b0};
            FMT_J:   imm32 = {{11{src[31]}}, src[31], src[19:12], src[20], src[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        dec_imm        = {XLEN{imm32[31]}};
        dec_imm[31:0]  = imm32;
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            opcode    <= '0;
            rd        <= '0;
            func3     <= '0;
            rs1       <= '0;
            rs2       <= '0;
            func7     <= '0;
            imm       <= '0;
            fmt       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (ld) begin
            if (pop || bypass) begin
                out_valid <= 1'b1;
                opcode    <= src[6:0];
                rd        <= src[11:7];
                func3     <= src[14:12];
                rs1       <= src[19:15];
                rs2       <= src[24:20];
                func7     <= src[31:25];
                imm       <= dec_imm;
                fmt       <= dec_fmt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ILLEGAL_DETECT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal <= 1'b0;
        else if (!flush && ld && (pop || bypass))
            illegal <= (dec_fmt == FMT_NONE) || (src[1:0] != 2'b11);
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Randomized bench for instruction_decode_queue against a queue-based arrival-order model.
module tb_instruction_decode_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready, out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3, fmt;
    logic [31:0] imm;
    logic        illegal;
    logic [2:0]  count;

    logic        v64 = 1'b0;
    logic [31:0] i64 = '0;
    logic        ir64, ov64, il64;
    logic [6:0]  op64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;
    logic [63:0] imm64;
    logic [1:0]  cnt64;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    instruction_decode_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2), .func7(func7),
        .imm(imm), .fmt(fmt), .illegal(illegal), .count(count)
    );

    instruction_decode_queue #(.DEPTH(2), .XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(v64), .in_instr(i64), .in_ready(ir64),
        .out_valid(ov64), .out_ready(1'b1),
        .opcode(op64), .rd(rd64), .func3(f3_64), .rs1(rs1_64), .rs2(rs2_64), .func7(f7_64),
        .imm(imm64), .fmt(fmt64), .illegal(il64), .count(cnt64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the ISA field rules.
    function automatic void ref_decode(input logic [31:0] i, output logic [2:0] f,
                                       output logic [63:0] im, output logic il);
        logic [31:0] v;
        case (i[6:0])
            7'h33:                      f = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: f = 3'd1;
            7'h23:                      f = 3'd2;
            7'h63:                      f = 3'd3;
            7'h37, 7'h17:               f = 3'd4;
            7'h6F:                      f = 3'd5;
            default:                    f = 3'd6;
        endcase
        case (f)
            3'd1:    v = {{20{i[31]}}, i[31:20]};
            3'd2:    v = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3:    v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    v = {i[31:12], 12'b0};
            3'd5:    v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v = 32'd0;
        endcase
        im = {{32{v[31]}}, v};
`ifdef ILLEGAL_DETECT_EN
        il = (f == 3'd6) || (i[1:0] != 2'b11);
`else
        il = 1'b0;
`endif
    endfunction

    task automatic check_all();
        logic [2:0] f; logic [63:0] im; logic il; int fifo_n;
        fifo_n = q.size() - ((q.size() > 0) ? 1 : 0);
        chk("in_ready", in_ready, fifo_n < DEPTH);
        chk("out_valid", out_valid, q.size() > 0);
        chk("count", count, q.size());
        if (q.size() > 0) begin
            ref_decode(q[0], f, im, il);
            chk("opcode", opcode, q[0][6:0]);
            chk("rd", rd, q[0][11:7]);
            chk("func3", func3, q[0][14:12]);
            chk("rs1", rs1, q[0][19:15]);
            chk("rs2", rs2, q[0][24:20]);
            chk("func7", func7, q[0][31:25]);
            chk("imm", imm, im[31:0]);
            chk("fmt", fmt, f);
            chk("illegal", illegal, il);
        end
    endtask

    // One cycle: check at negedge, drive, model the edge, return at next negedge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        bit rdy;
        check_all();
        in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            rdy = (q.size() - ((q.size() > 0) ? 1 : 0)) < DEPTH;
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && rdy) q.push_back(ins);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(0, 9) == 0) return t;
        return {t[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    initial begin
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_opcode", opcode, 0);
        chk("rst_imm", imm, 0);
        chk("rst_fmt", fmt, 0);
        chk("rst_illegal", illegal, 0);
        @(negedge clk);
        reset = 1'b0;

        // addi x1,x0,5
        cyc(1'b1, 32'h00500093, 1'b1, 1'b0);
        chk("addi_valid", out_valid, 1);
        chk("addi_opcode", opcode, 7'h13);
        chk("addi_rd", rd, 1);
        chk("addi_rs1", rs1, 0);
        chk("addi_fmt", fmt, 1);
        chk("addi_imm", imm, 5);
        chk("addi_count", count, 1);

        // beq with negative offset
        cyc(1'b1, 32'hFE208EE3, 1'b1, 1'b0);
        chk("beq_fmt", fmt, 3);
        chk("beq_imm", imm, 32'hFFFFFFFC);

        // lui into the 64-bit instance
        v64 = 1'b1; i64 = 32'h800000B7;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        v64 = 1'b0;
        chk("lui64_valid", ov64, 1);
        chk("lui64_fmt", fmt64, 4);
        chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);

        // unknown opcode
        cyc(1'b1, 32'h0000007F, 1'b1, 1'b0);
        chk("bad_fmt", fmt, 6);
`ifdef ILLEGAL_DETECT_EN
        chk("bad_illegal", illegal, 1);
`else
        chk("bad_illegal", illegal, 0);
`endif

        // backpressure: 6 offered, 5 held
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, rnd_instr(), 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 5);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained_valid", out_valid, 0);

        // flush beats a concurrent input
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd_instr(), 1'b0, 1'b0);
        cyc(1'b1, rnd_instr(), 1'b0, 1'b1);
        chk("flush_valid", out_valid, 0);
        chk("flush_count", count, 0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 9) < 5,
                $urandom_range(0, 49) == 0);

        // reset mid-stream, outputs must clear without a clock edge
        for (int i = 0; i < 4; i++) cyc(1'b1, rnd_instr(), 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_opcode", opcode, 0);
        chk("mid_rst_imm", imm, 0);
        chk("mid_rst_imm64", imm64, 0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++)
            cyc($urandom_range(0, 9) < 6, rnd_instr(), $urandom_range(0, 9) < 6, 1'b0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
